// File: rtl/demux_16_bank.sv
// Sixteen-slot register bank that is filled either by a ready/valid stream
// (slot 0 upward) or by indexed direct writes while no stream fill is active.
module demux_16_bank #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15,
  output logic [15:0]      filled,
  output logic [3:0]       ptr,
  output logic             busy,
  output logic             frame_done
);

  localparam int SLOTS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       ptr_next;
  logic [15:0]      filled_next;
  logic             xfer;
  logic             direct;
  logic             wr_go;
  logic [3:0]       wr_idx;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] bank [SLOTS];

  // Write port arbitration: the stream owns the bank during FILL, and a clear
  // on the same edge cancels the transfer.
  always_comb begin
    xfer    = (state == FILL) && s_valid && !clear;
    direct  = (state != FILL) && wr_en;
    wr_go   = 1'b0;
    wr_idx  = ptr;
    wr_word = s_data;
    if (xfer) begin
      wr_go   = 1'b1;
      wr_idx  = ptr;
      wr_word = s_data;
    end else if (direct) begin
      wr_go   = 1'b1;
      wr_idx  = wr_sel;
      wr_word = wr_data;
    end
  end

  // Next-state logic; start clears filled after any coincident direct write
  // has set its bit, so that bit ends up cleared.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    filled_next = filled;
    if (wr_go) begin
      filled_next = filled | (16'd1 << wr_idx);
    end
    if (clear) begin
      state_next = IDLE;
      ptr_next   = 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_next  = FILL;
            ptr_next    = 4'd0;
            filled_next = 16'd0;
          end
        end
        FILL: begin
          if (xfer) begin
            ptr_next = ptr + 4'd1;
            if (ptr == 4'd15) begin
              state_next = DONE;
            end
          end
        end
        default: begin
          state_next = IDLE;
          ptr_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 4'd0;
      filled <= 16'd0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      filled <= filled_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SLOTS; k++) begin
        bank[k] <= '0;
      end
    end else if (wr_go) begin
      bank[wr_idx] <= wr_word;
    end
  end

  assign s_ready    = (state == FILL);
  assign busy       = (state == FILL);
  assign frame_done = (state == DONE);

  assign out0  = bank[0];
  assign out1  = bank[1];
  assign out2  = bank[2];
  assign out3  = bank[3];
  assign out4  = bank[4];
  assign out5  = bank[5];
  assign out6  = bank[6];
  assign out7  = bank[7];
  assign out8  = bank[8];
  assign out9  = bank[9];
  assign out10 = bank[10];
  assign out11 = bank[11];
  assign out12 = bank[12];
  assign out13 = bank[13];
  assign out14 = bank[14];
  assign out15 = bank[15];

endmodule
